screen_ctrl: RTL and testbench
==============================

Name: screen_ctrl

Overview:
Top-level screen/game-flow controller directly downstream of the menu renderer. Consumes the menu's RGB and map selection, plus the game renderer's RGB. Sequences MENU -> LOAD -> PLAY -> OVER and drives game-core control strobes. Outputs the final registered pixel colour to the VGA output stage.

Parameters:
COLOR_BITS, 24, total RGB width; each channel is COLOR_BITS/3 bits.
LOAD_FRAMES, 30, number of frame starts the screen stays blanked in LOAD (1..255).
OVER_FRAMES, 120, number of frame starts the dimmed game-over screen is held before auto-return to MENU (1..255).

Ports:
clk_i  in  1  pixel clock
reset_i  in  1  synchronous, active-high reset
hpos_i  in  10  current pixel column
vpos_i  in  10  current pixel row
display_on_i  in  1  visible-area flag; low forces black output
start_i  in  1  raw start button, level
back_i  in  1  raw back/abort button, level
map_type_i  in  2  map currently highlighted by the menu
menu_red_i / menu_green_i / menu_blue_i  in  COLOR_BITS/3 each  menu pixel
game_red_i / game_green_i / game_blue_i  in  COLOR_BITS/3 each  game pixel
game_over_i  in  1  level from game core: a player has lost
red_o / green_o / blue_o  out  COLOR_BITS/3 each  final pixel, registered
map_sel_o  out  2  map latched at game start
game_reset_o  out  1  held high throughout LOAD
game_run_o  out  1  high only in PLAY
menu_active_o  out  1  high only in MENU; gates menu arrow movement

Behaviour:
- Button inputs: start_i and back_i each go through the existing pos_edge_detect. Every state decision uses the one-cycle edge pulses start_p and back_p.
- Frame tick:
  - frame_tick is a 1-cycle pulse on the first clk_i cycle where hpos_i==0 && vpos_i==0.
  - Implemented as the rising edge of that compare, registered.
  - If the position is held for several cycles, only one tick is produced.
- frame_cnt: 8-bit counter. Cleared on every state change. Increments on frame_tick. Saturates at 255.
- State machine (state_t): MENU, LOAD, PLAY, OVER. Reset state is MENU.
  - MENU:
    - start_p: map_sel_o <= map_type_i, go to LOAD.
    - back_p is ignored.
  - LOAD:
    - When frame_tick occurs with frame_cnt==LOAD_FRAMES-1, go to PLAY.
    - back_p: go to MENU, with priority over the timeout.
  - PLAY:
    - game_over_i: go to OVER.
    - else back_p: go to MENU.
    - game_over_i has priority over back_p.
  - OVER:
    - start_p: go to MENU immediately.
    - else when frame_tick occurs with frame_cnt==OVER_FRAMES-1, go to MENU.
- map_sel_o is written only on the MENU->LOAD transition. It holds through LOAD, PLAY and OVER and is not cleared on the return to MENU.
- Control outputs are registered decodes of the next state, so each is valid in the first cycle of the new state:
  - game_reset_o = (state==LOAD)
  - game_run_o = (state==PLAY)
  - menu_active_o = (state==MENU)
- Pixel path (one register stage, latency exactly 1 clk_i from hpos/vpos and colour inputs to red/green/blue_o):
  - display_on_i==0: output 0.
  - MENU: menu colour.
  - LOAD: 0 (black).
  - PLAY: game colour.
  - OVER: game colour, each channel logically shifted right by 1 (half intensity).
  - The mux selects on the current state register. On a transition cycle the pixel of that cycle still uses the old state.
- Reset values: state MENU, frame_cnt 0, map_sel_o 0, game_reset_o 0, game_run_o 0, menu_active_o 1, RGB 0, edge-detector history 0.
- Reset mid-operation: any state returns to MENU on the next edge. map_sel_o returns to 0.
- Simultaneous events:
  - start_p with back_p in MENU: start wins.
  - start_p in LOAD or PLAY is ignored.
  - start_p with timeout in OVER: both lead to MENU; same result.

Optional Feature:
SCREEN_CTRL_PAUSE_EN:
- When defined, adds state PAUSE. In PLAY, start_p goes to PAUSE (game_over_i and back_p keep priority).
- In PAUSE:
  - game_run_o=0 and game_reset_o=0.
  - Pixel is the game colour dimmed by shift right by 2.
  - start_p returns to PLAY.
  - back_p goes to MENU.
  - game_over_i is ignored.
- When undefined, the PAUSE state, its encoding and its logic do not exist, and start_p in PLAY is ignored.

Decomposition:
- Shared package screen_pkg:
  - state_t enum (2-bit; 3-bit-safe encoding so PAUSE can be added)
  - map_t (2-bit)
  - FRAME_CNT_W = 8
- Sub-module screen_pix_mux:
  - Purely combinational colour select/dim on (state, display_on).
  - Registered in the parent.
- Edge detection reuses the existing pos_edge_detect.

Test Plan:
- Reset, then hold hpos=vpos=5 -> menu_active_o=1, map_sel_o=0. RGB output equals the menu pixel one cycle after display_on_i=1, and 0 when display_on_i=0.
- map_type_i=2, pulse start_i -> map_sel_o=2 and game_reset_o=1 on the next cycle. After exactly LOAD_FRAMES (set 3) frame ticks: game_run_o=1, game_reset_o=0. RGB is 0 throughout LOAD.
- In PLAY, game pixel 0xFF/0x80/0x02 then raise game_over_i -> OVER; output becomes 0x7F/0x40/0x01. With OVER_FRAMES=4, MENU is re-entered after 4 ticks. map_sel_o is still 2.
- In PLAY, assert back_i and game_over_i in the same cycle -> OVER, not MENU. In LOAD, back_i -> MENU. Holding start_i high for 10 cycles gives only one transition.
- Hold hpos=vpos=0 for 5 cycles during LOAD -> frame_cnt increments once.
- Assert reset_i mid-PLAY -> next cycle: MENU, map_sel_o=0, game_run_o=0. With SCREEN_CTRL_PAUSE_EN: start in PLAY -> PAUSE with dim-by-4 pixel; start again -> PLAY.

Source files
------------

// File: rtl/screen_pkg.sv
// ---------------------------------------------------------------------------
// screen_pkg
// Shared types and constants for the screen/game-flow controller.
//   state_t     : screen state encoding. The default build uses 2 bits.
//                 MENU/LOAD/PLAY/OVER occupy the low codes. With
//                 SCREEN_CTRL_PAUSE_EN defined the enum widens to 3 bits
//                 and adds PAUSE, leaving the other codes unchanged.
//   map_t       : map selector as produced by the menu.
//   FRAME_CNT_W : width of the frame-start counter.
//   sat_inc     : saturating increment helper for the frame counter.
// Optional feature macro: SCREEN_CTRL_PAUSE_EN
// ---------------------------------------------------------------------------
package screen_pkg;

    localparam int FRAME_CNT_W = 8;

`ifdef SCREEN_CTRL_PAUSE_EN
    typedef enum logic [2:0] {
        MENU  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        OVER  = 3'd3,
        PAUSE = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        MENU = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        OVER = 2'd3
    } state_t;
`endif

    typedef logic [1:0] map_t;

    // Counter sticks at all-ones instead of wrapping back to a timeout value.
    function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pos_edge_detect.sv
// ---------------------------------------------------------------------------
// pos_edge_detect
// Turns a level input into a single-cycle pulse on its rising edge.
//   clk_i   : clock
//   reset_i : synchronous active-high reset; clears the history bit
//   sig_i   : level input
//   pulse_o : high for the one cycle where sig_i is 1 and was 0 last cycle
// ---------------------------------------------------------------------------
module pos_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/screen_pix_mux.sv
// ---------------------------------------------------------------------------
// screen_pix_mux
// Combinational colour selection for the screen controller. The parent
// registers the result.
//   state_i                         : current screen state
//   display_on_i                    : visible-area flag; low forces black
//   menu_red_i/green_i/blue_i       : menu renderer pixel
//   game_red_i/green_i/blue_i       : game renderer pixel
//   red_o/green_o/blue_o            : selected (possibly dimmed) pixel
// MENU shows the menu pixel. LOAD is black. PLAY shows the game pixel.
// OVER shows the game pixel at half intensity. PAUSE shows it at quarter
// intensity; PAUSE exists only with SCREEN_CTRL_PAUSE_EN.
// ---------------------------------------------------------------------------
module screen_pix_mux
    import screen_pkg::*;
#(
    parameter int CW = 8
) (
    input  state_t        state_i,
    input  logic          display_on_i,
    input  logic [CW-1:0] menu_red_i,
    input  logic [CW-1:0] menu_green_i,
    input  logic [CW-1:0] menu_blue_i,
    input  logic [CW-1:0] game_red_i,
    input  logic [CW-1:0] game_green_i,
    input  logic [CW-1:0] game_blue_i,
    output logic [CW-1:0] red_o,
    output logic [CW-1:0] green_o,
    output logic [CW-1:0] blue_o
);

    always_comb begin
        red_o   = '0;
        green_o = '0;
        blue_o  = '0;
        if (display_on_i) begin
            case (state_i)
                MENU: begin
                    red_o   = menu_red_i;
                    green_o = menu_green_i;
                    blue_o  = menu_blue_i;
                end
                LOAD: begin
                    red_o   = '0;
                    green_o = '0;
                    blue_o  = '0;
                end
                PLAY: begin
                    red_o   = game_red_i;
                    green_o = game_green_i;
                    blue_o  = game_blue_i;
                end
                OVER: begin
                    // Logical shift: half intensity per channel.
                    red_o   = game_red_i   >> 1;
                    green_o = game_green_i >> 1;
                    blue_o  = game_blue_i  >> 1;
                end
`ifdef SCREEN_CTRL_PAUSE_EN
                PAUSE: begin
                    red_o   = game_red_i   >> 2;
                    green_o = game_green_i >> 2;
                    blue_o  = game_blue_i  >> 2;
                end
`endif
                default: begin
                    red_o   = '0;
                    green_o = '0;
                    blue_o  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/screen_ctrl.sv
// ---------------------------------------------------------------------------
// screen_ctrl
// Screen/game-flow controller. It sits directly downstream of the menu
// renderer and sequences MENU -> LOAD -> PLAY -> OVER. It drives the
// game-core control strobes and outputs the registered final pixel.
//
// Ports
//   clk_i, reset_i                   : pixel clock, synchronous active-high reset
//   hpos_i, vpos_i                   : current pixel column / row
//   display_on_i                     : visible-area flag
//   start_i, back_i                  : raw button levels (edge-detected here)
//   map_type_i                       : map highlighted by the menu
//   menu_{red,green,blue}_i          : menu pixel
//   game_{red,green,blue}_i          : game pixel
//   game_over_i                      : level from the game core
//   {red,green,blue}_o               : final pixel, one register stage
//   map_sel_o                        : map latched on MENU->LOAD
//   game_reset_o                     : high throughout LOAD
//   game_run_o                       : high only in PLAY
//   menu_active_o                    : high only in MENU
//
// Parameters
//   COLOR_BITS  : total RGB width; each channel gets COLOR_BITS/3 bits
//   LOAD_FRAMES : frame starts spent blanked in LOAD (1..255)
//   OVER_FRAMES : frame starts the game-over screen is held (1..255)
//
// Optional feature macro: SCREEN_CTRL_PAUSE_EN. When defined, start in PLAY
// enters PAUSE with a quarter-intensity game pixel. In PAUSE, start resumes
// PLAY and back goes to MENU.
// ---------------------------------------------------------------------------
module screen_ctrl
    import screen_pkg::*;
#(
    parameter int COLOR_BITS  = 24,
    parameter int LOAD_FRAMES = 30,
    parameter int OVER_FRAMES = 120
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [9:0]              hpos_i,
    input  logic [9:0]              vpos_i,
    input  logic                    display_on_i,
    input  logic                    start_i,
    input  logic                    back_i,
    input  map_t                    map_type_i,
    input  logic [COLOR_BITS/3-1:0] menu_red_i,
    input  logic [COLOR_BITS/3-1:0] menu_green_i,
    input  logic [COLOR_BITS/3-1:0] menu_blue_i,
    input  logic [COLOR_BITS/3-1:0] game_red_i,
    input  logic [COLOR_BITS/3-1:0] game_green_i,
    input  logic [COLOR_BITS/3-1:0] game_blue_i,
    input  logic                    game_over_i,
    output logic [COLOR_BITS/3-1:0] red_o,
    output logic [COLOR_BITS/3-1:0] green_o,
    output logic [COLOR_BITS/3-1:0] blue_o,
    output map_t                    map_sel_o,
    output logic                    game_reset_o,
    output logic                    game_run_o,
    output logic                    menu_active_o
);

    localparam int CW = COLOR_BITS / 3;
    localparam logic [FRAME_CNT_W-1:0] LOAD_LAST = FRAME_CNT_W'(LOAD_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] OVER_LAST = FRAME_CNT_W'(OVER_FRAMES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   start_p;
    logic                   back_p;
    logic                   at_origin;
    logic                   origin_q;
    logic                   frame_tick;
    logic [CW-1:0]          mux_red;
    logic [CW-1:0]          mux_green;
    logic [CW-1:0]          mux_blue;

    // Button edge pulses: every decision below uses these, never the levels.
    pos_edge_detect u_start_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (start_i),
        .pulse_o (start_p)
    );

    pos_edge_detect u_back_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (back_i),
        .pulse_o (back_p)
    );

    // Frame start is the rising edge of the origin compare. A position held
    // at (0,0) for several clocks therefore yields a single tick.
    assign at_origin  = (hpos_i == '0) && (vpos_i == '0);
    assign frame_tick = at_origin & ~origin_q;

    // Next-state decode. The ordering of the if/else chains encodes the
    // event priorities in each state.
    always_comb begin
        state_next = state;
        case (state)
            MENU: begin
                if (start_p) state_next = LOAD;
            end
            LOAD: begin
                if (back_p)                                     state_next = MENU;
                else if (frame_tick && (frame_cnt == LOAD_LAST)) state_next = PLAY;
            end
            PLAY: begin
                if (game_over_i)  state_next = OVER;
                else if (back_p)  state_next = MENU;
`ifdef SCREEN_CTRL_PAUSE_EN
                else if (start_p) state_next = PAUSE;
`endif
            end
            OVER: begin
                if (start_p)                                    state_next = MENU;
                else if (frame_tick && (frame_cnt == OVER_LAST)) state_next = MENU;
            end
`ifdef SCREEN_CTRL_PAUSE_EN
            PAUSE: begin
                if (start_p)     state_next = PLAY;
                else if (back_p) state_next = MENU;
            end
`endif
            default: state_next = MENU;
        endcase
    end

    // State register, frame counter, map latch and control strobes. The
    // strobes decode state_next so they are valid in the first cycle of the
    // new state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= MENU;
            frame_cnt     <= '0;
            map_sel_o     <= '0;
            game_reset_o  <= 1'b0;
            game_run_o    <= 1'b0;
            menu_active_o <= 1'b1;
            origin_q      <= 1'b0;
        end else begin
            state    <= state_next;
            origin_q <= at_origin;

            // A state change takes precedence over a coincident tick, so
            // every state starts counting from zero.
            if (state_next != state) begin
                frame_cnt <= '0;
            end else if (frame_tick) begin
                frame_cnt <= sat_inc(frame_cnt);
            end

            // The map is latched only on game start. It deliberately
            // survives the return to MENU.
            if ((state == MENU) && (state_next == LOAD)) begin
                map_sel_o <= map_type_i;
            end

            game_reset_o  <= (state_next == LOAD);
            game_run_o    <= (state_next == PLAY);
            menu_active_o <= (state_next == MENU);
        end
    end

    // The colour mux looks at the current state. On a transition cycle that
    // cycle's pixel still follows the old state.
    screen_pix_mux #(
        .CW (CW)
    ) u_pix_mux (
        .state_i      (state),
        .display_on_i (display_on_i),
        .menu_red_i   (menu_red_i),
        .menu_green_i (menu_green_i),
        .menu_blue_i  (menu_blue_i),
        .game_red_i   (game_red_i),
        .game_green_i (game_green_i),
        .game_blue_i  (game_blue_i),
        .red_o        (mux_red),
        .green_o      (mux_green),
        .blue_o       (mux_blue)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            red_o   <= mux_red;
            green_o <= mux_green;
            blue_o  <= mux_blue;
        end
    end

endmodule

// File: tb/tb_screen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_screen_ctrl
// Testbench for screen_ctrl with LOAD_FRAMES=3, OVER_FRAMES=4, 24-bit colour.
// The expected pixel for each cycle is pushed to exp_q when the inputs are
// driven and popped one clock later. The expected state is hand-tracked by
// the sequences. Control outputs are checked against constants at the
// interesting points.
// ---------------------------------------------------------------------------
module tb_screen_ctrl;
    import screen_pkg::*;

    localparam int CW = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i;
    logic [9:0]    hpos_i;
    logic [9:0]    vpos_i;
    logic          display_on_i;
    logic          start_i;
    logic          back_i;
    map_t          map_type_i;
    logic [23:0]   menu_rgb;
    logic [23:0]   game_rgb;
    logic          game_over_i;
    logic [CW-1:0] red_o;
    logic [CW-1:0] green_o;
    logic [CW-1:0] blue_o;
    map_t          map_sel_o;
    logic          game_reset_o;
    logic          game_run_o;
    logic          menu_active_o;

    screen_ctrl #(
        .COLOR_BITS  (24),
        .LOAD_FRAMES (3),
        .OVER_FRAMES (4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .hpos_i        (hpos_i),
        .vpos_i        (vpos_i),
        .display_on_i  (display_on_i),
        .start_i       (start_i),
        .back_i        (back_i),
        .map_type_i    (map_type_i),
        .menu_red_i    (menu_rgb[23:16]),
        .menu_green_i  (menu_rgb[15:8]),
        .menu_blue_i   (menu_rgb[7:0]),
        .game_red_i    (game_rgb[23:16]),
        .game_green_i  (game_rgb[15:8]),
        .game_blue_i   (game_rgb[7:0]),
        .game_over_i   (game_over_i),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .map_sel_o     (map_sel_o),
        .game_reset_o  (game_reset_o),
        .game_run_o    (game_run_o),
        .menu_active_o (menu_active_o)
    );

    // scoreboard
    logic [23:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    state_t      exp_state;

    typedef struct {
        logic        disp;
        logic [23:0] menu;
        logic [23:0] game;
        logic [23:0] exp;
    } pix_vec_t;

    pix_vec_t vecs[6];

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix_model(input state_t s, input logic disp,
                                              input logic [23:0] m, input logic [23:0] g);
        logic [7:0] r, gr, b;
        r  = g[23:16];
        gr = g[15:8];
        b  = g[7:0];
        if (!disp) return 24'h0;
        case (s)
            MENU:    return m;
            LOAD:    return 24'h0;
            PLAY:    return g;
            OVER:    return {r >> 1, gr >> 1, b >> 1};
`ifdef SCREEN_CTRL_PAUSE_EN
            PAUSE:   return {r >> 2, gr >> 2, b >> 2};
`endif
            default: return 24'h0;
        endcase
    endfunction

    // driver tasks
    task automatic step(input logic [23:0] exp_pix);
        logic [23:0] e;
        exp_q.push_back(exp_pix);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pixel", {red_o, green_o, blue_o}, e);
    endtask

    task automatic cycle();
        step(reset_i ? 24'h0 : pix_model(exp_state, display_on_i, menu_rgb, game_rgb));
    endtask

    // One frame start; exp_state takes nxt right after the tick edge.
    task automatic frame_to(input state_t nxt);
        hpos_i = 10'd0;
        vpos_i = 10'd0;
        cycle();
        exp_state = nxt;
        hpos_i = 10'd5;
        vpos_i = 10'd5;
        cycle();
    endtask

    task automatic press_start(input state_t nxt);
        start_i = 1'b1;
        cycle();
        exp_state = nxt;
        start_i = 1'b0;
    endtask

    task automatic menu_to_play(input map_t m);
        map_type_i = m;
        press_start(LOAD);
        frame_to(LOAD);
        frame_to(LOAD);
        frame_to(PLAY);
    endtask

    initial begin
        reset_i      = 1'b1;
        hpos_i       = 10'd5;
        vpos_i       = 10'd5;
        display_on_i = 1'b1;
        start_i      = 1'b0;
        back_i       = 1'b0;
        map_type_i   = 2'd0;
        menu_rgb     = 24'hA0B0C0;
        game_rgb     = 24'h123456;
        game_over_i  = 1'b0;
        exp_state    = MENU;

        vecs[0] = '{1'b1, 24'hA0B0C0, 24'h123456, 24'hA0B0C0};
        vecs[1] = '{1'b0, 24'hA0B0C0, 24'h123456, 24'h000000};
        vecs[2] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        vecs[3] = '{1'b1, 24'h010203, 24'hFFFFFF, 24'h010203};
        vecs[4] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        vecs[5] = '{1'b1, 24'h00FF00, 24'h777777, 24'h00FF00};

        // reset
        cycle();
        cycle();
        check("rst_menu_active", 24'(menu_active_o), 24'd1);
        check("rst_map_sel",     24'(map_sel_o),     24'd0);
        check("rst_game_reset",  24'(game_reset_o),  24'd0);
        check("rst_game_run",    24'(game_run_o),    24'd0);
        reset_i = 1'b0;
        cycle();

        // MENU pixel table
        for (int i = 0; i < 6; i++) begin
            display_on_i = vecs[i].disp;
            menu_rgb     = vecs[i].menu;
            game_rgb     = vecs[i].game;
            step(vecs[i].exp);
        end
        display_on_i = 1'b1;
        menu_rgb     = 24'hA0B0C0;
        game_rgb     = 24'h123456;
        check("menu_active", 24'(menu_active_o), 24'd1);

        // start held for 10 cycles: one MENU->LOAD transition only
        map_type_i = 2'd2;
        start_i    = 1'b1;
        cycle();
        exp_state = LOAD;
        check("load_map_sel",    24'(map_sel_o),     24'd2);
        check("load_game_reset", 24'(game_reset_o),  24'd1);
        check("load_menu_off",   24'(menu_active_o), 24'd0);
        repeat (9) cycle();
        start_i = 1'b0;
        check("start_held_once", 24'(game_reset_o), 24'd1);

        // origin held for 5 cycles counts as one frame start
        hpos_i = 10'd0;
        vpos_i = 10'd0;
        repeat (5) cycle();
        hpos_i = 10'd5;
        vpos_i = 10'd5;
        cycle();
        check("hold_one_tick", 24'(game_reset_o), 24'd1);
        frame_to(LOAD);
        check("load_2_ticks_run", 24'(game_run_o), 24'd0);
        frame_to(PLAY);
        check("play_run",   24'(game_run_o),   24'd1);
        check("play_reset", 24'(game_reset_o), 24'd0);

        // PLAY -> OVER with dimmed pixel, timeout back to MENU
        game_rgb = 24'hFF8002;
        cycle();
        cycle();
        game_over_i = 1'b1;
        cycle();
        exp_state = OVER;
        check("over_run",  24'(game_run_o),    24'd0);
        check("over_menu", 24'(menu_active_o), 24'd0);
        cycle();
        game_over_i = 1'b0;
        check("over_pix", {red_o, green_o, blue_o}, 24'h7F4001);
        frame_to(OVER);
        frame_to(OVER);
        frame_to(OVER);
        check("over_3_ticks", 24'(menu_active_o), 24'd0);
        frame_to(MENU);
        check("over_timeout_menu", 24'(menu_active_o), 24'd1);
        check("map_sel_kept",      24'(map_sel_o),     24'd2);

        // back ignored in MENU; start+back together in MENU -> LOAD
        back_i = 1'b1;
        cycle();
        back_i = 1'b0;
        check("menu_back_ignored", 24'(menu_active_o), 24'd1);
        cycle();
        start_i    = 1'b1;
        back_i     = 1'b1;
        map_type_i = 2'd1;
        cycle();
        exp_state = LOAD;
        start_i = 1'b0;
        back_i  = 1'b0;
        check("start_wins",   24'(game_reset_o), 24'd1);
        check("map_sel_1",    24'(map_sel_o),    24'd1);
        cycle();
        back_i = 1'b1;
        cycle();
        exp_state = MENU;
        back_i = 1'b0;
        check("load_back_menu",  24'(menu_active_o), 24'd1);
        check("load_back_reset", 24'(game_reset_o),  24'd0);
        cycle();

        // back and game_over together in PLAY -> OVER; start in OVER -> MENU
        menu_to_play(2'd3);
        check("play2_run", 24'(game_run_o), 24'd1);
        check("map_sel_3", 24'(map_sel_o),  24'd3);
        back_i      = 1'b1;
        game_over_i = 1'b1;
        cycle();
        exp_state = OVER;
        back_i      = 1'b0;
        game_over_i = 1'b0;
        check("over_prio_run",  24'(game_run_o),    24'd0);
        check("over_prio_menu", 24'(menu_active_o), 24'd0);
        cycle();
        press_start(MENU);
        check("over_start_menu", 24'(menu_active_o), 24'd1);
        cycle();

        // start in PLAY: pause when enabled, ignored otherwise
        menu_to_play(2'd2);
`ifdef SCREEN_CTRL_PAUSE_EN
        press_start(PAUSE);
        check("pause_run",   24'(game_run_o),   24'd0);
        check("pause_reset", 24'(game_reset_o), 24'd0);
        game_rgb = 24'hFF8002;
        cycle();
        check("pause_pix", {red_o, green_o, blue_o}, 24'h3F2000);
        game_over_i = 1'b1;
        cycle();
        game_over_i = 1'b0;
        check("pause_over_ignored", 24'(game_run_o), 24'd0);
        press_start(PLAY);
        check("resume_run", 24'(game_run_o), 24'd1);
`else
        press_start(PLAY);
        check("play_start_ignored", 24'(game_run_o), 24'd1);
`endif
        cycle();

        // reset mid-PLAY
        reset_i = 1'b1;
        cycle();
        exp_state = MENU;
        reset_i = 1'b0;
        check("mid_rst_menu",    24'(menu_active_o), 24'd1);
        check("mid_rst_map_sel", 24'(map_sel_o),     24'd0);
        check("mid_rst_run",     24'(game_run_o),    24'd0);
        check("mid_rst_reset",   24'(game_reset_o),  24'd0);
        cycle();
        cycle();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
